// File: rtl/note_sequencer_if.sv
// Control and status bundle between the chart player and its neighbours.
// The player takes the slave side; the stimulus/controller side takes master.
interface note_sequencer_if #(
    parameter int LANES = 4,
    parameter int STEPS = 32
);
    localparam int SW = $clog2(STEPS);

    logic             frame_i;
    logic             start_i;
    logic             stop_i;
    logic [LANES-1:0] spawn_o;
    logic             beat_o;
    logic [SW-1:0]    step_o;
    logic             running_o;
    logic             done_o;

    modport master (
        output frame_i, start_i, stop_i,
        input  spawn_o, beat_o, step_o, running_o, done_o
    );

    modport slave (
        input  frame_i, start_i, stop_i,
        output spawn_o, beat_o, step_o, running_o, done_o
    );
endinterface

// File: rtl/note_sequencer.sv
// Chart player: counts frame ticks, walks a fixed step chart, emits per-lane spawn and beat pulses.
// All outputs registered, one cycle after the qualifying frame tick; no backpressure (pulses are fire-and-forget).
module note_sequencer #(
    parameter int                       LANES           = 4,
    parameter int                       STEPS           = 32,
    parameter int                       FRAMES_PER_STEP = 15,
    parameter int                       LEAD_STEPS      = 4,
    parameter bit                       LOOP            = 1'b0,
    parameter logic [LANES*STEPS-1:0]   CHART           = {STEPS{4'b0001}}
) (
    input  logic               clk_i,
    input  logic               rst_i,
    note_sequencer_if.slave    bus
);
    localparam int SW = $clog2(STEPS);
    localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int LW = (LEAD_STEPS > 1) ? $clog2(LEAD_STEPS) : 1;

    localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_STEP - 1);
    localparam logic [LW-1:0] L_LAST = LW'((LEAD_STEPS > 0) ? LEAD_STEPS - 1 : 0);
    localparam logic [SW-1:0] S_LAST = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           r_state, w_state_nx;
    logic [FW-1:0]    r_fcnt,  w_fcnt_nx;
    logic [LW-1:0]    r_lcnt,  w_lcnt_nx;
    logic [SW-1:0]    r_step,  w_step_nx;
    logic [LANES-1:0] r_spawn, w_spawn_nx;
    logic             r_beat,  w_beat_nx;
    logic             r_done,  w_done_nx;
    logic             w_fcnt_last;

    assign w_fcnt_last = (r_fcnt == F_LAST);

    always_comb begin
        w_state_nx = r_state;
        w_fcnt_nx  = r_fcnt;
        w_lcnt_nx  = r_lcnt;
        w_step_nx  = r_step;
        w_spawn_nx = '0;
        w_beat_nx  = 1'b0;
        w_done_nx  = 1'b0;

        case (r_state)
            IDLE: begin
                // stop beats start when both arrive together
                if (bus.start_i && !bus.stop_i) begin
                    w_fcnt_nx  = '0;
                    w_lcnt_nx  = '0;
                    w_step_nx  = '0;
                    w_state_nx = (LEAD_STEPS == 0) ? RUN : LEAD;
                end
            end

            LEAD: begin
                if (bus.stop_i) begin
                    w_state_nx = IDLE;
                    w_fcnt_nx  = '0;
                    w_lcnt_nx  = '0;
                    w_step_nx  = '0;
                end else if (bus.frame_i) begin
                    w_beat_nx = (r_fcnt == '0);
                    if (w_fcnt_last) begin
                        w_fcnt_nx = '0;
                        if (r_lcnt == L_LAST) begin
                            w_lcnt_nx  = '0;
                            w_step_nx  = '0;
                            w_state_nx = RUN;
                        end else begin
                            w_lcnt_nx = r_lcnt + 1'b1;
                        end
                    end else begin
                        w_fcnt_nx = r_fcnt + 1'b1;
                    end
                end
            end

            RUN: begin
                if (bus.stop_i) begin
                    w_state_nx = IDLE;
                    w_fcnt_nx  = '0;
                    w_lcnt_nx  = '0;
                    w_step_nx  = '0;
                end else if (bus.frame_i) begin
                    if (r_fcnt == '0) begin
                        w_beat_nx  = 1'b1;
                        w_spawn_nx = CHART[r_step*LANES +: LANES];
                    end
                    // with one frame per step the spawn above and this advance share a tick
                    if (w_fcnt_last) begin
                        w_fcnt_nx = '0;
                        if (r_step < S_LAST) begin
                            w_step_nx = r_step + 1'b1;
                        end else if (LOOP) begin
                            w_step_nx = '0;
                        end else begin
                            w_step_nx  = '0;
                            w_state_nx = IDLE;
                            w_done_nx  = 1'b1;
                        end
                    end else begin
                        w_fcnt_nx = r_fcnt + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nx = IDLE;
                w_fcnt_nx  = '0;
                w_lcnt_nx  = '0;
                w_step_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_fcnt  <= '0;
            r_lcnt  <= '0;
            r_step  <= '0;
            r_spawn <= '0;
            r_beat  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_fcnt  <= w_fcnt_nx;
            r_lcnt  <= w_lcnt_nx;
            r_step  <= w_step_nx;
            r_spawn <= w_spawn_nx;
            r_beat  <= w_beat_nx;
            r_done  <= w_done_nx;
        end
    end

    // step is held at 0 outside RUN, so it doubles as the registered step output
    assign bus.spawn_o   = r_spawn;
    assign bus.beat_o    = r_beat;
    assign bus.done_o    = r_done;
    assign bus.step_o    = r_step;
    assign bus.running_o = (r_state != IDLE);
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: basic, loop, no-lead, stop, start collisions and mid-run reset.
module tb_note_sequencer;
    localparam logic [15:0] CH = 16'h8421;

    // expected outputs after frames 1..10 of a 4-step, 2-frame, 1-lead chart
    localparam logic [3:0] E_SP [10] = '{4'h0, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0};
    localparam logic       E_BT [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam logic [1:0] E_ST [10] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    note_sequencer_if #(.LANES(4), .STEPS(4)) if_b ();
    note_sequencer_if #(.LANES(4), .STEPS(4)) if_l ();
    note_sequencer_if #(.LANES(4), .STEPS(4)) if_n ();

    note_sequencer #(.LANES(4), .STEPS(4), .FRAMES_PER_STEP(2), .LEAD_STEPS(1), .LOOP(1'b0), .CHART(CH))
        u_basic (.clk_i(clk), .rst_i(rst), .bus(if_b));
    note_sequencer #(.LANES(4), .STEPS(4), .FRAMES_PER_STEP(2), .LEAD_STEPS(1), .LOOP(1'b1), .CHART(CH))
        u_loop (.clk_i(clk), .rst_i(rst), .bus(if_l));
    note_sequencer #(.LANES(4), .STEPS(4), .FRAMES_PER_STEP(1), .LEAD_STEPS(0), .LOOP(1'b0), .CHART(CH))
        u_nolead (.clk_i(clk), .rst_i(rst), .bus(if_n));

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [3:0] o_spawn;
    logic       o_beat;
    logic [1:0] o_step;
    logic       o_run;
    logic       o_done;

    task automatic drive(input int d, input logic f, input logic st, input logic sp);
        case (d)
            0: begin if_b.frame_i = f; if_b.start_i = st; if_b.stop_i = sp; end
            1: begin if_l.frame_i = f; if_l.start_i = st; if_l.stop_i = sp; end
            default: begin if_n.frame_i = f; if_n.start_i = st; if_n.stop_i = sp; end
        endcase
    endtask

    task automatic sample(input int d);
        case (d)
            0: begin o_spawn = if_b.spawn_o; o_beat = if_b.beat_o; o_step = if_b.step_o;
                     o_run = if_b.running_o; o_done = if_b.done_o; end
            1: begin o_spawn = if_l.spawn_o; o_beat = if_l.beat_o; o_step = if_l.step_o;
                     o_run = if_l.running_o; o_done = if_l.done_o; end
            default: begin o_spawn = if_n.spawn_o; o_beat = if_n.beat_o; o_step = if_n.step_o;
                     o_run = if_n.running_o; o_done = if_n.done_o; end
        endcase
    endtask

    // one clock with the given inputs; outputs sampled 1 time unit after the edge
    task automatic tick(input int d, input logic f, input logic st, input logic sp);
        drive(d, f, st, sp);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, 1'b0);
        sample(d);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] sp, input logic bt,
                           input logic [1:0] st, input logic rn, input logic dn);
        chk({tag, " spawn"},   32'(o_spawn), 32'(sp));
        chk({tag, " beat"},    32'(o_beat),  32'(bt));
        chk({tag, " step"},    32'(o_step),  32'(st));
        chk({tag, " running"}, 32'(o_run),   32'(rn));
        chk({tag, " done"},    32'(o_done),  32'(dn));
    endtask

    // frames 1..nfr of the 2-frame chart, each followed by an idle cycle that must hold state
    task automatic play(input int d, input int nfr, input bit start_at4, input bit loop_mode);
        logic end_now;
        for (int k = 0; k < nfr; k++) begin
            end_now = (k == 9) && !loop_mode;
            tick(d, 1'b1, (start_at4 && k == 3), 1'b0);
            chk_all($sformatf("d%0d frame%0d", d, k + 1), E_SP[k], E_BT[k], E_ST[k], !end_now, end_now);
            tick(d, 1'b0, 1'b0, 1'b0);
            chk_all($sformatf("d%0d hold%0d", d, k + 1), 4'h0, 1'b0, E_ST[k], !end_now, 1'b0);
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0, 1'b0);
        drive(2, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        sample(0);
        chk_all("reset", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

        // basic run with a start pulse at frame 4 that must be ignored
        tick(0, 1'b0, 1'b1, 1'b0);
        chk_all("start", 4'h0, 1'b0, 2'd0, 1'b1, 1'b0);
        play(0, 10, 1'b1, 1'b0);

        tick(0, 1'b1, 1'b0, 1'b0);
        chk_all("idle frame", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

        tick(0, 1'b0, 1'b1, 1'b1);
        chk("start+stop running", 32'(o_run), 32'd0);
        tick(0, 1'b1, 1'b0, 1'b0);
        chk_all("after start+stop", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);

        // stop coincident with frame 5 suppresses the spawn
        tick(0, 1'b0, 1'b1, 1'b0);
        play(0, 4, 1'b0, 1'b0);
        tick(0, 1'b1, 1'b0, 1'b1);
        chk_all("stop@f5", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick(0, 1'b1, 1'b0, 1'b0);
            chk_all($sformatf("post-stop f%0d", k), 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        end

        // reset mid-run at step 2, then replay from the lead
        tick(0, 1'b0, 1'b1, 1'b0);
        play(0, 6, 1'b0, 1'b0);
        rst = 1'b1;
        tick(0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk_all("mid-run reset", 4'h0, 1'b0, 2'd0, 1'b0, 1'b0);
        tick(0, 1'b0, 1'b1, 1'b0);
        chk("restart running", 32'(o_run), 32'd1);
        play(0, 3, 1'b0, 1'b0);
        tick(0, 1'b0, 1'b0, 1'b1);

        // looping chart wraps to step 0 without done
        tick(1, 1'b0, 1'b1, 1'b0);
        play(1, 10, 1'b0, 1'b1);
        tick(1, 1'b1, 1'b0, 1'b0);
        chk_all("loop f11", 4'h1, 1'b1, 2'd0, 1'b1, 1'b0);
        tick(1, 1'b0, 1'b0, 1'b1);

        // no lead, one frame per step: spawn on the very first frame
        tick(2, 1'b0, 1'b1, 1'b0);
        chk("nolead running", 32'(o_run), 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick(2, 1'b1, 1'b0, 1'b0);
            chk($sformatf("nolead f%0d spawn", k + 1), 32'(o_spawn), 32'(4'h1 << k));
            chk($sformatf("nolead f%0d beat", k + 1), 32'(o_beat), 32'd1);
            chk($sformatf("nolead f%0d done", k + 1), 32'(o_done), 32'(k == 3));
            chk($sformatf("nolead f%0d running", k + 1), 32'(o_run), 32'(k != 3));
        end
        tick(2, 1'b0, 1'b0, 1'b0);
        chk("nolead done width", 32'(o_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/note_sequencer.md
# note_sequencer

Chart player for the DDR game. It sits directly upstream of the arrow logic stage. It counts vertical-blank frame ticks, walks a fixed step chart, and issues one-cycle per-lane spawn pulses that the arrow logic uses to launch new arrows. It also provides a count-in lead, a metronome beat, and run/done status for the score and display stages.

## Interface
- `LANES`, default 4: number of arrow lanes. Lane 0 = left, 1 = down, 2 = up, 3 = right.
- `STEPS`, default 32: number of chart steps. Must be ≥ 2.
- `FRAMES_PER_STEP`, default 15: frame ticks per step, giving 4 steps/s at 60 Hz. Must be ≥ 1.
- `LEAD_STEPS`, default 4: silent count-in steps before step 0. 0 is allowed.
- `LOOP`, default 0: 1 = wrap to step 0 after the last step; 0 = stop and flag done.
- `CHART`, default `{STEPS{4'b0001}}`: `LANES*STEPS` bits. Bit `CHART[s*LANES + l]` = spawn in lane `l` at step `s`.
- `clk_i`, in, 1: pixel clock. The block uses one clock only.
- `rst_i`, in, 1: synchronous, active-high reset.
- `frame_i`, in, 1: one-cycle pulse at the start of vertical blanking.
- `start_i`, in, 1: one-cycle pulse (debounced button) that starts the chart.
- `stop_i`, in, 1: one-cycle pulse that aborts the chart.
- `spawn_o`, out, `LANES`: one-cycle spawn pulses, all lanes of a step asserted together.
- `beat_o`, out, 1: one-cycle metronome pulse at each step start (lead and run).
- `step_o`, out, `$clog2(STEPS)`: index of the current run step. 0 outside RUN.
- `running_o`, out, 1: high in LEAD or RUN.
- `done_o`, out, 1: one-cycle pulse when a non-looping chart completes.

## Operation
- State machine: IDLE, LEAD, RUN.
- Internal counters:
  - `fcnt`: 0..FRAMES_PER_STEP-1, width `max(1, $clog2(FRAMES_PER_STEP))`.
  - `lcnt`: 0..LEAD_STEPS-1.
  - `step`: 0..STEPS-1.
- Counters advance only on `frame_i`. Cycles without `frame_i` hold all state, apart from `start_i`/`stop_i` handling.
- IDLE:
  - On `start_i`, clear `fcnt`, `lcnt` and `step`.
  - Go to LEAD, or directly to RUN if `LEAD_STEPS == 0`.
  - `frame_i` is ignored.
- LEAD:
  - On `frame_i`, if `fcnt == 0`, pulse `beat_o`. Then `fcnt` increments.
  - When `fcnt == FRAMES_PER_STEP-1`, `fcnt` returns to 0 and `lcnt` increments.
  - When that wrap happens with `lcnt == LEAD_STEPS-1`, go to RUN with `fcnt = 0` and `step = 0`.
  - `spawn_o` stays 0.
- RUN:
  - On `frame_i`, if `fcnt == 0`, pulse `beat_o` and set `spawn_o = CHART[step*LANES +: LANES]`. An all-zero slice gives a beat with no spawn.
  - On `frame_i` with `fcnt == FRAMES_PER_STEP-1`, `fcnt` returns to 0. Then:
    - if `step < STEPS-1`, `step` increments;
    - else if `LOOP = 1`, `step` returns to 0;
    - else go to IDLE and pulse `done_o`.
- The last step always receives its full FRAMES_PER_STEP frames before done.
- `stop_i` in LEAD or RUN:
  - Go to IDLE and clear the counters.
  - No `spawn_o`, `beat_o` or `done_o` in the following cycle, even if `frame_i` is coincident.
  - `done_o` is not pulsed.
- Simultaneous events:
  - `start_i` and `stop_i` together: stop wins and the block stays in or returns to IDLE.
  - `start_i` while in LEAD or RUN is ignored, so there is no restart.
- `FRAMES_PER_STEP == 1`: every `frame_i` is both a step start and a step end. Spawn and advance happen on the same tick.

## Timing
- Reset: state IDLE, all counters 0, and `spawn_o`, `beat_o`, `done_o`, `running_o`, `step_o` all 0.
- Reset is applied mid-chart identically to `stop_i`, but with full counter clear.
- All outputs are registered.
- `spawn_o`, `beat_o` and `done_o` assert exactly one cycle after the qualifying `frame_i` and are high for one cycle.
- `running_o` rises the cycle after the accepted `start_i`. It falls the cycle after the completing `frame_i` or after `stop_i`.
- `step_o` updates the cycle after the advancing `frame_i`. It is therefore stable for the whole step and valid alongside `spawn_o`.
- Spawn pulses occur in the vertical blanking interval, before the arrow stage's frame update.

## Test plan
- Basic run. Parameters: `STEPS=4`, `FRAMES_PER_STEP=2`, `LEAD_STEPS=1`, `LOOP=0`, `CHART=16'h8421`. Stimulus: `start_i`, then 10 `frame_i` pulses.
  - `beat_o` fires after frames 1, 3, 5, 7 and 9.
  - `spawn_o` is 0001, 0010, 0100 and 1000 after frames 3, 5, 7 and 9; 0 otherwise.
  - `done_o` fires after frame 10, and `running_o` then falls.
- Loop. Same setup with `LOOP=1`: frame 11 gives `spawn_o = 0001` with `step_o = 0`, and `done_o` never pulses.
- Stop with coincident frame. Same setup: `stop_i` coincident with frame 5 gives no spawn. The block enters IDLE and `running_o` is 0 next cycle. Further `frame_i` pulses give no output.
- Simultaneous and ignored starts. `start_i` together with `stop_i` from IDLE keeps the block in IDLE. `start_i` at frame 4 of a run is ignored, and the spawn sequence is unchanged.
- No lead. `LEAD_STEPS=0`, `FRAMES_PER_STEP=1`: `start_i` then frame 1 gives `spawn_o = 0001` immediately, and frame 4 gives 1000 followed by `done_o` one cycle after frame 4.
- Reset. Assert `rst_i` mid-RUN (`step_o = 2`): the next cycle shows all outputs 0 and IDLE. A subsequent `start_i` replays the chart from the lead.
